// File: rtl/ofdm_pilot_mapper_if.sv
// Carrier-stream bus between QAM mapper, pilot mapper and IFFT buffer.
// slave is the mapper's view; master is the surrounding environment.
interface ofdm_pilot_mapper_if #(
  parameter int DW = 16
);
  logic [2*DW-1:0] DAT_I;
  logic            CYC_I;
  logic            STB_I;
  logic            WE_I;
  logic            ACK_O;
  logic [2*DW-1:0] DAT_O;
  logic            CYC_O;
  logic            STB_O;
  logic            WE_O;
  logic            ACK_I;

  modport slave (
    input  DAT_I, CYC_I, STB_I, WE_I, ACK_I,
    output ACK_O, DAT_O, CYC_O, STB_O, WE_O
  );

  modport master (
    output DAT_I, CYC_I, STB_I, WE_I, ACK_I,
    input  ACK_O, DAT_O, CYC_O, STB_O, WE_O
  );
endinterface

// File: rtl/ofdm_pilot_mapper.sv
// Per-symbol null/pilot/data carrier mapper feeding the IFFT buffer.
// Pilot polarity follows an x^11+x^9+1 LFSR stepped once per symbol.
module ofdm_pilot_mapper #(
  parameter int          DW        = 16,
  parameter int          NLOG2_MAX = 11,
  parameter logic [DW-1:0] PIL_AMP = 16'h7fff,
  parameter logic [10:0] PRBS_SEED = 11'h7ff
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  ofdm_pilot_mapper_if.slave          bus,
  input  logic [1:0]                  NFFT_SEL,
  input  logic [(2<<NLOG2_MAX)-1:0]   ALLOC_VEC,
  output logic                        VEC_LD,
  input  logic                        PRBS_EN,
  output logic                        SYM_DONE,
  output logic                        SYM_ABORT
);

  localparam int AW = 2 << NLOG2_MAX;

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_CAP, RUN, DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        alloc_q;
  logic [NLOG2_MAX-1:0] cnt_q, last_cnt;
  logic [1:0]           nsel_q;
  logic [10:0]          lfsr_q;
  logic                 cyc_q, last_q, abort_q;
  logic                 cyc_o_q, stb_q;
  logic [2*DW-1:0]      dat_q, dat_d;
  logic [DW-1:0]        pil_neg;
  logic [1:0]           code;
  logic                 run, is_data, out_rdy, ack;
  logic                 emit, emit_last, abort, cyc_rise, neg;

  assign code      = alloc_q[1:0];
  assign run       = state_q == RUN;
  assign is_data   = code == 2'b10;
  assign out_rdy   = ~stb_q | bus.ACK_I;
  assign ack       = bus.CYC_I & bus.STB_I & bus.WE_I
                   & out_rdy & run & is_data;
  assign emit      = run & out_rdy & (~is_data | ack);
  assign emit_last = emit & (cnt_q == last_cnt);
  assign abort     = run & ~bus.CYC_I & is_data;
  assign cyc_rise  = bus.CYC_I & ~cyc_q;
  assign neg       = code[1] ^ (PRBS_EN & lfsr_q[0]);
  assign pil_neg   = ~PIL_AMP + DW'(1);

  assign bus.ACK_O = ack;
  assign bus.DAT_O = dat_q;
  assign bus.STB_O = stb_q;
  assign bus.WE_O  = stb_q;
  assign bus.CYC_O = cyc_o_q;
  assign VEC_LD    = state_q == LOAD_REQ;
  assign SYM_DONE  = stb_q & bus.ACK_I & last_q;
  assign SYM_ABORT = abort_q;

  always_comb begin
    unique case (nsel_q)
      2'b01:   last_cnt = NLOG2_MAX'(255);
      2'b10:   last_cnt = NLOG2_MAX'(2047);
      default: last_cnt = NLOG2_MAX'(63);
    endcase
  end

  always_comb begin
    dat_d = '0;
    if (is_data)
      dat_d = bus.DAT_I;
    else if (code[0])
      dat_d = {{DW{1'b0}}, neg ? pil_neg : PIL_AMP};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cyc_rise) state_d = LOAD_REQ;
      LOAD_REQ: state_d = LOAD_CAP;
      LOAD_CAP: state_d = RUN;
      RUN: begin
        if (emit_last)
          state_d = bus.CYC_I ? LOAD_REQ : DRAIN;
        else if (abort)
          state_d = DRAIN;
      end
      DRAIN:    if (out_rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      alloc_q <= '0;
      cnt_q   <= '0;
      nsel_q  <= '0;
      lfsr_q  <= PRBS_SEED;
      cyc_q   <= 1'b0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
      cyc_o_q <= 1'b0;
      stb_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= bus.CYC_I;
      abort_q <= abort;
      if (state_q == IDLE && cyc_rise)
        lfsr_q <= PRBS_SEED;
      else if (emit_last)
        lfsr_q <= {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
      if (state_q == LOAD_CAP) begin
        alloc_q <= ALLOC_VEC;
        nsel_q  <= NFFT_SEL;
        cnt_q   <= '0;
        cyc_o_q <= 1'b1;
      end else if (emit) begin
        alloc_q <= alloc_q >> 2;
        cnt_q   <= emit_last ? '0 : cnt_q + NLOG2_MAX'(1);
      end
      if (state_q == DRAIN && out_rdy)
        cyc_o_q <= 1'b0;
      // A new word may replace an accepted one in the same cycle
      if (emit) begin
        dat_q  <= dat_d;
        stb_q  <= 1'b1;
        last_q <= emit_last;
      end else if (bus.ACK_I) begin
        stb_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_pilot_mapper.sv
// Scoreboard bench for ofdm_pilot_mapper: directed symbols,
// expected words queued at issue and popped on each accepted output.
module tb_ofdm_pilot_mapper;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [1:0]    nfft_sel;
  logic [4095:0] alloc;
  logic          vec_ld;
  logic          prbs_en;
  logic          sym_done;
  logic          sym_abort;

  ofdm_pilot_mapper_if #(.DW(16)) bus ();

  ofdm_pilot_mapper #(.DW(16)) dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .bus       (bus),
    .NFFT_SEL  (nfft_sel),
    .ALLOC_VEC (alloc),
    .VEC_LD    (vec_ld),
    .PRBS_EN   (prbs_en),
    .SYM_DONE  (sym_done),
    .SYM_ABORT (sym_abort)
  );

  exp_t       q[$];
  logic [1:0] codes [2048];
  int         checks = 0;
  int         errors = 0;
  int         pops = 0, ack_cnt = 0, vld_cnt = 0;
  int         done_cnt = 0, abort_cnt = 0;
  int         didx = 0, pidx = 0;
  bit         ack_tog = 0;
  bit         hold_chk = 0;
  logic [31:0] hold_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(int k);
    return 32'h0001_0002 + 32'(k) * 32'h0001_0001;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int ev_val(int sel);
    case (sel)
      0: return pops;
      1: return done_cnt;
      2: return vld_cnt;
      3: return ack_cnt;
      default: return bus.CYC_O ? 0 : 1;
    endcase
  endfunction

  task automatic wait_ev(string nm, int sel, int target, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ev_val(sel) >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles", nm, budget);
  endtask

  // 0:T1 layout 1:all +pilot 2:all data 3:restart 4:null/data
  task automatic set_codes(int pat);
    for (int i = 0; i < 2048; i++) begin
      case (pat)
        0: codes[i] = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 :
                      (i < 64) ? 2'b10 : 2'b01;
        1: codes[i] = 2'b01;
        2: codes[i] = 2'b10;
        3: codes[i] = (i == 0) ? 2'b01 : (i == 1) ? 2'b00 : 2'b10;
        default: codes[i] = i[0] ? 2'b10 : 2'b00;
      endcase
      alloc[2*i +: 2] = codes[i];
    end
  endtask

  task automatic push_exp(int n_emit, int n_tot, bit sgn);
    exp_t e;
    for (int i = 0; i < n_emit; i++) begin
      e.last = (i == n_tot - 1);
      case (codes[i])
        2'b00: e.d = 32'h0;
        2'b10: begin e.d = word(pidx); pidx++; end
        default: e.d = (codes[i][1] ^ sgn) ? 32'h0000_8001
                                           : 32'h0000_7fff;
      endcase
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.CYC_I = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    pidx = didx;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  // Upstream source: advance to the next word after each accept
  initial begin
    bit a;
    bus.DAT_I = word(0);
    forever begin
      @(negedge clk);
      a = bus.ACK_O;
      @(posedge clk); #1;
      if (a && !rst) didx++;
      bus.DAT_I = word(didx);
    end
  end

  initial begin
    bus.ACK_I = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.ACK_I = ack_tog ? ~bus.ACK_I : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_chk = 0;
      end else begin
        if (bus.ACK_O) ack_cnt++;
        if (vec_ld)    vld_cnt++;
        if (sym_done)  done_cnt++;
        if (sym_abort) abort_cnt++;
        if (hold_chk) begin
          chk("hold_stb", 32'(bus.STB_O), 32'd1);
          chk("hold_dat", bus.DAT_O, hold_d);
        end
        hold_chk = bus.STB_O && !bus.ACK_I;
        hold_d   = bus.DAT_O;
        if (bus.STB_O && bus.ACK_I) begin
          pops++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none",
                     bus.DAT_O);
          end else begin
            e = q.pop_front();
            chk("dat_o", bus.DAT_O, e.d);
            chk("sym_done", 32'(sym_done), 32'(e.last));
            chk("we_o", 32'(bus.WE_O), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int b_pop, b_ack, b_done, b_vld, b_abt;
    rst = 1'b1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    nfft_sel  = 2'b00;
    prbs_en   = 1'b0;
    alloc     = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stb",   32'(bus.STB_O), 32'd0);
    chk("rst_cyc",   32'(bus.CYC_O), 32'd0);
    chk("rst_we",    32'(bus.WE_O),  32'd0);
    chk("rst_ack",   32'(bus.ACK_O), 32'd0);
    chk("rst_vecld", 32'(vec_ld),    32'd0);
    chk("rst_done",  32'(sym_done),  32'd0);
    chk("rst_abort", 32'(sym_abort), 32'd0);
    chk("rst_dat",   bus.DAT_O,      32'd0);
    do_reset();

    // T1: null, +pilot, 62 data, full-rate accept
    set_codes(0);
    push_exp(64, 64, 1'b0);
    b_pop = pops; b_ack = ack_cnt; b_done = done_cnt;
    bus.CYC_I = 1'b1;
    wait_ev("t1_done", 1, b_done + 1, 500);
    chk("t1_words", 32'(pops - b_pop), 32'd64);
    chk("t1_acks", 32'(ack_cnt - b_ack), 32'd62);
    chk("t1_q", 32'(q.size()), 32'd0);
    do_reset();

    // T2: same symbol, downstream accept every other cycle
    ack_tog = 1;
    push_exp(64, 64, 1'b0);
    b_pop = pops; b_done = done_cnt;
    bus.CYC_I = 1'b1;
    wait_ev("t2_done", 1, b_done + 1, 1000);
    chk("t2_words", 32'(pops - b_pop), 32'd64);
    chk("t2_q", 32'(q.size()), 32'd0);
    ack_tog = 0;
    do_reset();

    // T3: PRBS pilots, 3 symbols, drop CYC_I during the third
    prbs_en = 1'b1;
    set_codes(1);
    push_exp(64, 64, 1'b1);
    push_exp(64, 64, 1'b0);
    push_exp(64, 64, 1'b0);
    b_pop = pops; b_done = done_cnt; b_vld = vld_cnt;
    bus.CYC_I = 1'b1;
    wait_ev("t3_vld", 2, b_vld + 3, 500);
    bus.CYC_I = 1'b0;
    wait_ev("t3_done", 1, b_done + 3, 500);
    wait_ev("t3_cyc", 4, 1, 50);
    chk("t3_words", 32'(pops - b_pop), 32'd192);
    chk("t3_vld", 32'(vld_cnt - b_vld), 32'd3);
    chk("t3_cyc_o", 32'(bus.CYC_O), 32'd0);

    // T4: abort at data carrier 10, then restart with seed
    set_codes(2);
    push_exp(10, 64, 1'b1);
    b_pop = pops; b_ack = ack_cnt; b_done = done_cnt; b_abt = abort_cnt;
    bus.CYC_I = 1'b1;
    wait_ev("t4_ack", 3, b_ack + 10, 200);
    @(posedge clk); #1;
    bus.CYC_I = 1'b0;
    wait_ev("t4_cyc", 4, 1, 50);
    repeat (2) @(negedge clk);
    #1;
    chk("t4_abort", 32'(abort_cnt - b_abt), 32'd1);
    chk("t4_words", 32'(pops - b_pop), 32'd10);
    chk("t4_acks", 32'(ack_cnt - b_ack), 32'd10);
    chk("t4_done", 32'(done_cnt - b_done), 32'd0);
    set_codes(3);
    push_exp(2, 64, 1'b1);
    b_pop = pops;
    bus.CYC_I = 1'b1;
    wait_ev("t4_restart", 0, b_pop + 2, 50);
    chk("t4_q", 32'(q.size()), 32'd0);
    do_reset();

    // T5: 2048 carriers alternating null/data
    prbs_en = 1'b0;
    nfft_sel = 2'b10;
    set_codes(4);
    push_exp(2048, 2048, 1'b0);
    b_pop = pops; b_ack = ack_cnt; b_done = done_cnt;
    bus.CYC_I = 1'b1;
    wait_ev("t5_done", 1, b_done + 1, 5000);
    chk("t5_words", 32'(pops - b_pop), 32'd2048);
    chk("t5_acks", 32'(ack_cnt - b_ack), 32'd1024);
    chk("t5_q", 32'(q.size()), 32'd0);
    do_reset();

    // T6: asynchronous reset mid-symbol, then clean restart
    nfft_sel = 2'b00;
    set_codes(0);
    push_exp(64, 64, 1'b0);
    b_pop = pops;
    bus.CYC_I = 1'b1;
    wait_ev("t6_run", 0, b_pop + 5, 50);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_stb",   32'(bus.STB_O), 32'd0);
    chk("t6_cyc",   32'(bus.CYC_O), 32'd0);
    chk("t6_vecld", 32'(vec_ld),    32'd0);
    chk("t6_dat",   bus.DAT_O,      32'd0);
    chk("t6_ack",   32'(bus.ACK_O), 32'd0);
    do_reset();
    push_exp(4, 64, 1'b0);
    b_pop = pops;
    bus.CYC_I = 1'b1;
    wait_ev("t6_restart", 0, b_pop + 4, 50);
    chk("t6_q", 32'(q.size()), 32'd0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
